mul_by_add_datapath: RTL and testbench
======================================

Name: mul_by_add_datapath

Overview:
- Datapath stage driven by the multiply-by-repeated-addition controller; sits directly downstream of it.
- Consumes ldA/ldB/ldP/clrP/decB/done and returns eqz.
- Holds multiplicand A, down-counting multiplier B and accumulator P; computes P = A*B by repeated addition.
- Presents the finished product through a valid/ready result register with a sticky overflow flag.

Parameters:
- WIDTH, 8, width of data_in, A and B.
- PW, 16, width of accumulator P and res_data (PW >= WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- data_in  in  WIDTH  shared operand bus; A on ldA, B on ldB
- ldA  in  1  load A from data_in
- ldB  in  1  load B from data_in
- ldP  in  1  accumulate enable: P <= P + A
- clrP  in  1  clear P and overflow flag
- decB  in  1  decrement B
- done  in  1  controller finished; level, held high
- eqz  out  1  combinational: B == 0
- res_data  out  PW  captured product
- res_valid  out  1  res_data holds an unconsumed product
- res_ready  in  1  consumer accepts res_data
- res_ovf  out  1  overflow flag captured with res_data
- busy  out  1  high from ldB until result capture

Behaviour:
- Reset is asynchronous, active-high. A=0, B=0, P=0, ovf=0, res_data=0, res_valid=0, res_ovf=0, busy=0, done_q=0; eqz therefore 1.
- A: ldA -> A <= data_in at the next edge.
- B: ldB -> B <= data_in at the next edge. Otherwise decB & (B != 0) -> B <= B-1. B never wraps below 0.
- P:
  - clrP -> P <= 0 and ovf <= 0. clrP has priority over ldP in the same cycle.
  - Otherwise ldP & (B != 0) -> P <= P + zero-extended A, truncated to PW bits.
  - Gating ldP on B != 0 means the extra s3 cycle in which the controller samples eqz adds nothing. Result is exactly A*B mod 2^PW.
- ovf is set when a PW-bit accumulate carries out. It stays set until clrP or rst.
- ldA and ldB high together: both load the same data_in value.
- ldB together with decB: the load wins.
- eqz is purely combinational from B; it is valid in the same cycle B updates.
- busy:
  - Set on the edge where ldB is sampled.
  - Cleared on the edge where the result is captured.
- Result capture:
  - done_q registers done.
  - On done & ~done_q (rising edge of done): res_data <= P, res_ovf <= ovf, res_valid <= 1, busy <= 0.
  - Capture happens one cycle after the controller enters s4. P is final by then because the accumulate is gated.
- Handshake:
  - res_valid & res_ready at an edge -> res_valid <= 0.
  - res_data and res_ovf hold their values while res_valid=1 and res_ready=0.
  - If a new done rising edge coincides with a pending handshake, the capture wins: res_valid stays 1 with the new data.
- B=0 at load: eqz=1 immediately, no accumulate occurs, product is 0.
- A=0: B counts down normally, P stays 0.
- Reset mid-operation: all state returns to reset values at once; no partial result is presented.

Optional Feature:
- Macro MUL_ADD_ZERO_SKIP_EN.
- When defined: eqz = (B == 0) | (A == 0). B also stops decrementing and P stops accumulating once A == 0, so a multiply by zero terminates in the first s3 cycle.
- When undefined: eqz = (B == 0) only, and A=0 costs B iterations.
- res_data is identical in both builds.

Test Plan:
- A=5, B=3, WIDTH=8/PW=16, controller-style sequence (ldA; ldB+clrP; ldP+decB until eqz; done) -> eqz rises after 3 accumulates; res_valid=1, res_data=15, res_ovf=0, busy=0.
- A=0xFF, B=0xFF, PW=16 -> res_data=0xFE01, res_ovf=0. Repeat with PW=8 -> res_data=0x01, res_ovf=1.
- B=0, A=9 -> eqz=1 in the cycle after ldB; an extra ldP/decB cycle leaves P=0, B=0; res_data=0.
- res_ready held low 5 cycles after capture -> res_data/res_valid stable; res_ready=1 for one cycle -> res_valid=0 next edge.
- rst asserted asynchronously mid-accumulate (A=7, B=4, after 2 adds) -> all outputs return to reset values immediately without waiting for clk; eqz=1.
- With MUL_ADD_ZERO_SKIP_EN, A=0, B=200 -> eqz=1 immediately after loads, B stays 200, res_data=0. Without the macro -> eqz rises after 200 decrements, res_data=0.

Source files
------------

// File: rtl/mul_by_add_datapath.sv
// Datapath for multiply-by-repeated-addition: operand A, down-counting B, accumulator P,
// and a valid/ready result register. Optional build macro: MUL_ADD_ZERO_SKIP_EN.
module mul_by_add_datapath #(
    parameter int WIDTH = 8,
    parameter int PW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ldA,
    input  logic             ldB,
    input  logic             ldP,
    input  logic             clrP,
    input  logic             decB,
    input  logic             done,
    output logic             eqz,
    output logic [PW-1:0]    res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ovf,
    output logic             busy
);

    typedef struct packed {
        logic [PW-1:0] data;
        logic          ovf;
        logic          valid;
    } res_t;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_p;
    logic             r_ovf;
    logic             r_done_q;
    logic             r_busy;
    res_t             r_res;

    logic             w_b_nz;
    logic             w_step;
    logic [PW:0]      w_sum;
    logic             w_cap;

    assign w_b_nz = (r_b != '0);

`ifdef MUL_ADD_ZERO_SKIP_EN
    // A multiply by zero ends as soon as A is known to be zero.
    assign w_step = w_b_nz & (r_a != '0);
`else
    assign w_step = w_b_nz;
`endif

    assign eqz   = ~w_step;
    assign w_sum = {1'b0, r_p} + (PW+1)'(r_a);
    assign w_cap = done & ~r_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
        end else if (ldA) begin
            r_a <= data_in;
        end
    end

    // A load always beats a decrement; B saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b <= '0;
        end else if (ldB) begin
            r_b <= data_in;
        end else if (decB && w_step) begin
            r_b <= r_b - 1'b1;
        end
    end

    // Accumulate is gated on B != 0 so the controller's eqz-sampling cycle adds nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (clrP) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (ldP && w_step) begin
            r_p <= w_sum[PW-1:0];
            if (w_sum[PW]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= done;
        end
    end

    // A new operation start takes precedence over a coincident capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (ldB) begin
            r_busy <= 1'b1;
        end else if (w_cap) begin
            r_busy <= 1'b0;
        end
    end

    // Capture beats a coincident handshake so a fresh product is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (w_cap) begin
            r_res.data  <= r_p;
            r_res.ovf   <= r_ovf;
            r_res.valid <= 1'b1;
        end else if (r_res.valid && res_ready) begin
            r_res.valid <= 1'b0;
        end
    end

    assign res_data  = r_res.data;
    assign res_ovf   = r_res.ovf;
    assign res_valid = r_res.valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mul_by_add_datapath.sv
// Randomized self-checking bench: a PW=16 and a PW=8 instance share one stimulus stream
// and are compared against integer-arithmetic expectations of A*B.
module tb_mul_by_add_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        ldA, ldB, ldP, clrP, decB, done, res_ready;
    logic        eqz16, eqz8;
    logic [15:0] res_data16;
    logic [7:0]  res_data8;
    logic        res_valid16, res_valid8, res_ovf16, res_ovf8, busy16, busy8;

    int checks = 0;
    int errors = 0;

`ifdef MUL_ADD_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    always #5 clk = ~clk;

    mul_by_add_datapath #(.WIDTH(8), .PW(16)) dut16 (
        .clk(clk), .rst(rst), .data_in(data_in), .ldA(ldA), .ldB(ldB), .ldP(ldP),
        .clrP(clrP), .decB(decB), .done(done), .eqz(eqz16), .res_data(res_data16),
        .res_valid(res_valid16), .res_ready(res_ready), .res_ovf(res_ovf16), .busy(busy16)
    );

    mul_by_add_datapath #(.WIDTH(8), .PW(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(data_in), .ldA(ldA), .ldB(ldB), .ldP(ldP),
        .clrP(clrP), .decB(decB), .done(done), .eqz(eqz8), .res_data(res_data8),
        .res_valid(res_valid8), .res_ready(res_ready), .res_ovf(res_ovf8), .busy(busy8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ldA = 0; ldB = 0; ldP = 0; clrP = 0; decB = 0; done = 0; res_ready = 0; data_in = '0;
    endtask

    // Controller-style multiply; leaves the product pending. ready_at_cap drives res_ready
    // on the capture edge to exercise capture-over-handshake priority.
    task automatic run_mul(input int a, input int b, input bit ready_at_cap);
        int prod, exp_iter, n;
        prod     = a * b;
        exp_iter = (SKIP && a == 0) ? 0 : b;
        data_in = 8'(a); ldA = 1; tick();
        ldA = 0; data_in = 8'(b); ldB = 1; clrP = 1; tick();
        ldB = 0; clrP = 0;
        checks++;
        if (busy16 !== 1'b1 || eqz16 !== (exp_iter == 0)) begin
            errors++;
            $display("FAIL after_load a=%0d b=%0d: busy=%b eqz=%b, expected busy=1 eqz=%b",
                     a, b, busy16, eqz16, exp_iter == 0);
        end
        n = 0;
        while (eqz16 !== 1'b1 && n < 300) begin
            ldP = 1; decB = 1; tick(); n++;
        end
        ldP = 1; decB = 1; tick();   // eqz-sampling cycle: must add nothing
        ldP = 0; decB = 0;
        checks++;
        if (n != exp_iter) begin
            errors++;
            $display("FAIL iterations a=%0d b=%0d: got %0d expected %0d", a, b, n, exp_iter);
        end
        done = 1; res_ready = ready_at_cap; tick();
        done = 0; res_ready = 0;
        checks++;
        if (res_valid16 !== 1'b1 || res_data16 !== 16'(prod) || res_ovf16 !== (prod > 16'hFFFF)
            || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL result16 a=%0d b=%0d: v=%b data=%0h ovf=%b busy=%b, expected v=1 data=%0h ovf=%b busy=0",
                     a, b, res_valid16, res_data16, res_ovf16, busy16, 16'(prod), prod > 16'hFFFF);
        end
        checks++;
        if (res_valid8 !== 1'b1 || res_data8 !== 8'(prod) || res_ovf8 !== (prod > 8'hFF)) begin
            errors++;
            $display("FAIL result8 a=%0d b=%0d: v=%b data=%0h ovf=%b, expected v=1 data=%0h ovf=%b",
                     a, b, res_valid8, res_data8, res_ovf8, 8'(prod), prod > 8'hFF);
        end
    endtask

    task automatic consume();
        res_ready = 1; tick(); res_ready = 0;
        checks++;
        if (res_valid16 !== 1'b0 || res_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL consume: valid16=%b valid8=%b expected 0", res_valid16, res_valid8);
        end
    endtask

    task automatic test_reset();
        idle(); rst = 1; #12;
        checks++;
        if (eqz16 !== 1 || res_data16 !== 0 || res_valid16 !== 0 || res_ovf16 !== 0 || busy16 !== 0) begin
            errors++;
            $display("FAIL reset: eqz=%b data=%0h v=%b ovf=%b busy=%b expected 1,0,0,0,0",
                     eqz16, res_data16, res_valid16, res_ovf16, busy16);
        end
        rst = 0; tick();
    endtask

    task automatic test_directed();
        run_mul(5, 3, 0);     consume();
        run_mul(255, 255, 0); consume();
        run_mul(9, 0, 0);     consume();
        run_mul(0, 200, 0);   consume();
    endtask

    task automatic test_hold();
        run_mul(12, 11, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (res_valid16 !== 1'b1 || res_data16 !== 16'd132) begin
                errors++;
                $display("FAIL hold cyc%0d: v=%b data=%0d expected v=1 data=132", i, res_valid16, res_data16);
            end
        end
        consume();
    endtask

    task automatic test_back_to_back();
        run_mul(3, 4, 0);
        run_mul(6, 7, 1);     // handshake of 12 coincides with capture of 42
        consume();
    endtask

    task automatic test_load_collisions();
        int n;
        data_in = 8'd6; ldA = 1; ldB = 1; decB = 1; clrP = 1; tick();
        idle();
        n = 0;
        while (eqz16 !== 1'b1 && n < 300) begin
            ldP = 1; decB = 1; tick(); n++;
        end
        ldP = 0; decB = 0;
        done = 1; tick(); done = 0;
        checks++;
        if (n != 6 || res_data16 !== 16'd36) begin
            errors++;
            $display("FAIL collisions: iter=%0d data=%0d expected iter=6 data=36", n, res_data16);
        end
        consume();
    endtask

    task automatic test_async_reset();
        data_in = 8'd7; ldA = 1; tick();
        ldA = 0; data_in = 8'd4; ldB = 1; clrP = 1; tick();
        ldB = 0; clrP = 0; ldP = 1; decB = 1; tick(); tick();
        ldP = 0; decB = 0;
        #2 rst = 1;
        #1;
        checks++;
        if (eqz16 !== 1 || res_valid16 !== 0 || res_data16 !== 0 || res_ovf16 !== 0 || busy16 !== 0) begin
            errors++;
            $display("FAIL async_reset: eqz=%b v=%b data=%0h ovf=%b busy=%b expected 1,0,0,0,0",
                     eqz16, res_valid16, res_data16, res_ovf16, busy16);
        end
        tick(); rst = 0; tick();
        done = 1; tick(); done = 0;   // P was cleared, so capture yields zero
        checks++;
        if (res_data16 !== 0) begin
            errors++;
            $display("FAIL post_reset_capture: data=%0h expected 0", res_data16);
        end
        consume();
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 20; i++) begin
            a = (($urandom % 5) == 0) ? 0 : int'($urandom_range(255));
            b = (($urandom % 5) == 0) ? 0 : int'($urandom_range(255));
            run_mul(a, b, 0);
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_load_collisions();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
